// File: rtl/tank_input_decoder.sv
// Per-frame keycode decoder for two tank players: movement commands and fire pulses with cooldown.
// Define TANK_AUTOFIRE_EN to make a held fire key re-fire whenever its cooldown has expired.
module tank_input_decoder #(
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned CD_W            = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [31:0] keycode,
  output logic [3:0]  p1_move,
  output logic [3:0]  p2_move,
  output logic        p1_fire,
  output logic        p2_fire,
  output logic        p1_ready,
  output logic        p2_ready
);

  localparam logic [7:0] KEY_ERR   = 8'h01;
  localparam logic [7:0] KEY_P1_UP = 8'h1A;
  localparam logic [7:0] KEY_P1_DN = 8'h16;
  localparam logic [7:0] KEY_P1_LF = 8'h04;
  localparam logic [7:0] KEY_P1_RT = 8'h07;
  localparam logic [7:0] KEY_P1_FR = 8'h2C;
  localparam logic [7:0] KEY_P2_UP = 8'h52;
  localparam logic [7:0] KEY_P2_DN = 8'h51;
  localparam logic [7:0] KEY_P2_LF = 8'h50;
  localparam logic [7:0] KEY_P2_RT = 8'h4F;
  localparam logic [7:0] KEY_P2_FR = 8'h28;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  function automatic logic has_key(input logic [31:0] kc, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (kc[8*i +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  // Opposing pairs cancel; vertical beats horizontal, so at most one bit survives.
  function automatic logic [3:0] resolve(input logic up, input logic dn,
                                         input logic lf, input logic rt);
    logic vu, vd, hl, hr, vert;
    vu   = up & ~dn;
    vd   = dn & ~up;
    hl   = lf & ~rt;
    hr   = rt & ~lf;
    vert = vu | vd;
    return {vu, vd, hl & ~vert, hr & ~vert};
  endfunction

  logic            r_fc_s1, r_fc_s2, r_fc_prev;
  logic [3:0]      r_p1_move, r_p2_move;
  logic            r_p1_fire, r_p2_fire;
  logic            r_p1_ready, r_p2_ready;
  logic            r_p1_prev_fire, r_p2_prev_fire;
  logic [CD_W-1:0] r_p1_cd, r_p2_cd;

  logic            w_tick, w_err;
  logic            w_p1_key, w_p2_key, w_p1_press, w_p2_press;
  logic            w_p1_shot, w_p2_shot;
  logic [3:0]      w_p1_move, w_p2_move;
  logic [CD_W-1:0] w_p1_cd_nxt, w_p2_cd_nxt;

  assign w_tick = r_fc_s2 & ~r_fc_prev;
  assign w_err  = has_key(keycode, KEY_ERR);

  assign w_p1_move = resolve(has_key(keycode, KEY_P1_UP), has_key(keycode, KEY_P1_DN),
                             has_key(keycode, KEY_P1_LF), has_key(keycode, KEY_P1_RT));
  assign w_p2_move = resolve(has_key(keycode, KEY_P2_UP), has_key(keycode, KEY_P2_DN),
                             has_key(keycode, KEY_P2_LF), has_key(keycode, KEY_P2_RT));
  assign w_p1_key  = has_key(keycode, KEY_P1_FR);
  assign w_p2_key  = has_key(keycode, KEY_P2_FR);

`ifdef TANK_AUTOFIRE_EN
  assign w_p1_press = w_p1_key;
  assign w_p2_press = w_p2_key;
`else
  assign w_p1_press = w_p1_key & ~r_p1_prev_fire;
  assign w_p2_press = w_p2_key & ~r_p2_prev_fire;
`endif

  assign w_p1_shot = w_tick & ~w_err & w_p1_press & (r_p1_cd == '0);
  assign w_p2_shot = w_tick & ~w_err & w_p2_press & (r_p2_cd == '0);

  // Cooldown next-state: load on a shot, otherwise count down to zero once per tick.
  always_comb begin
    w_p1_cd_nxt = r_p1_cd;
    w_p2_cd_nxt = r_p2_cd;
    if (w_tick) begin
      if (w_p1_shot)           w_p1_cd_nxt = CD_LOAD;
      else if (r_p1_cd != '0)  w_p1_cd_nxt = r_p1_cd - CD_W'(1);
      if (w_p2_shot)           w_p2_cd_nxt = CD_LOAD;
      else if (r_p2_cd != '0)  w_p2_cd_nxt = r_p2_cd - CD_W'(1);
    end
  end

  // Synchronizer flops reset high so a high frame_clk at release is not seen as an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fc_s1        <= 1'b1;
      r_fc_s2        <= 1'b1;
      r_fc_prev      <= 1'b1;
      r_p1_move      <= '0;
      r_p2_move      <= '0;
      r_p1_fire      <= 1'b0;
      r_p2_fire      <= 1'b0;
      r_p1_ready     <= 1'b1;
      r_p2_ready     <= 1'b1;
      r_p1_prev_fire <= 1'b0;
      r_p2_prev_fire <= 1'b0;
      r_p1_cd        <= '0;
      r_p2_cd        <= '0;
    end else begin
      r_fc_s1    <= frame_clk;
      r_fc_s2    <= r_fc_s1;
      r_fc_prev  <= r_fc_s2;
      r_p1_fire  <= w_p1_shot;
      r_p2_fire  <= w_p2_shot;
      r_p1_cd    <= w_p1_cd_nxt;
      r_p2_cd    <= w_p2_cd_nxt;
      r_p1_ready <= (w_p1_cd_nxt == '0);
      r_p2_ready <= (w_p2_cd_nxt == '0);
      if (w_tick && !w_err) begin
        r_p1_move      <= w_p1_move;
        r_p2_move      <= w_p2_move;
        r_p1_prev_fire <= w_p1_key;
        r_p2_prev_fire <= w_p2_key;
      end
    end
  end

  assign p1_move  = r_p1_move;
  assign p2_move  = r_p2_move;
  assign p1_fire  = r_p1_fire;
  assign p2_fire  = r_p2_fire;
  assign p1_ready = r_p1_ready;
  assign p2_ready = r_p2_ready;

endmodule
